// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its execution controller: data width,
// register-file geometry, opcode encodings and the controller state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int REG_N  = 4;
    localparam int ADDR_W = 2;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [OP_W-1:0] OP_NAND = 3'b101;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CAPT  = 2'd2,
        ST_WB_HI = 2'd3
    } exec_state_t;

    // Only arithmetic ops produce a meaningful carry/borrow.
    function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake plus the ALU operand/result bus of the execution
// controller. master = instruction source / ALU side, slave = controller.
interface alu_exec_ctrl_if;
    import alu_pkg::*;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [OP_W-1:0]       instr_op;
    logic [ADDR_W-1:0]     instr_rd;
    logic [ADDR_W-1:0]     instr_rs;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [OP_W-1:0]       alu_op;
    logic [2*DATA_W-1:0]   alu_r;
    logic                  alu_c;
    logic                  alu_z;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs,
        input  instr_ready,
        input  alu_a, alu_b, alu_op,
        output alu_r, alu_c, alu_z
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs,
        output instr_ready,
        output alu_a, alu_b, alu_op,
        input  alu_r, alu_c, alu_z
    );

endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: two operand read ports, one debug read port, and two
// write ports where the writeback port overrides a same-register load.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] regs [REG_N];

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

    // register storage with writeback-over-load priority per entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                if (wb_en && (wb_addr == ADDR_W'(i)))
                    regs[i] <= wb_data;
                else if (ld_en && (ld_addr == ADDR_W'(i)))
                    regs[i] <= ld_data;
            end
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execution controller in front of the 8x8 ALU: accepts one reg-reg
// instruction, launches registered operands, captures the ALU result and
// writes it back (two bytes for Mul) together with the c/z flags.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for an instruction; operands launched on accept
// ST_EXEC  | ALU settling; result and flags captured at the end
// ST_CAPT  | low byte written to rd, flags updated; done unless Mul
// ST_WB_HI | Mul high byte written to rd+1 (wraps), done
module alu_exec_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_ctrl_if.slave    bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              flag_c,
    output logic              flag_z,
    output logic              done,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    exec_state_t         state, state_nxt;
    logic [OP_W-1:0]     op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [2*DATA_W-1:0] res_q;
    logic                res_c_q;
    logic                res_z_q;

    logic                accept;
    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                done_nxt;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;

    assign bus.instr_ready = (state == ST_IDLE);

    alu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (bus.instr_rd),
        .rd_data_a (rd_data_a),
        .rd_addr_b (bus.instr_rs),
        .rd_data_b (rd_data_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next state, accept strobe, writeback port and done request
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = rd_q;
        wb_data   = res_q[DATA_W-1:0];
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_CAPT;
            ST_CAPT: begin
                wb_en = 1'b1;
                if (op_q == OP_MUL) begin
                    state_nxt = ST_WB_HI;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WB_HI: begin
                wb_en     = 1'b1;
                wb_addr   = rd_q + ADDR_W'(1);
                wb_data   = res_q[2*DATA_W-1:DATA_W];
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // latch instruction fields and launch operands (pre-edge register values)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_ADD;
            rd_q       <= '0;
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
            bus.alu_op <= OP_ADD;
        end else if (accept) begin
            op_q       <= bus.instr_op;
            rd_q       <= bus.instr_rd;
            bus.alu_a  <= rd_data_a;
            bus.alu_b  <= rd_data_b;
            bus.alu_op <= bus.instr_op;
        end
    end

    // capture the settled ALU outputs at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            res_c_q <= 1'b0;
            res_z_q <= 1'b0;
        end else if (state == ST_EXEC) begin
            res_q   <= bus.alu_r;
            res_c_q <= bus.alu_c;
            res_z_q <= bus.alu_z;
        end
    end

    // architectural flags (carry only from Add/Sub) and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= done_nxt;
            if (state == ST_CAPT) begin
                flag_z <= res_z_q;
                if (op_sets_carry(op_q)) flag_c <= res_c_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed scenarios, then random instruction/load
// traffic. A cycle-scheduled reference model and scoreboard in the monitor
// predict operands, ready, done latency, flags and register contents.
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic       flag_c, flag_z, done;
    logic [1:0] dbg_addr, stim_dbg, mon_dbg;
    logic       dbg_sel;
    logic [7:0] dbg_data;

    always #5 clk = ~clk;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .done     (done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign dbg_addr = dbg_sel ? stim_dbg : mon_dbg;

    // ALU behaviour: returns {carry, zero, result}
    function automatic logic [17:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [7:0]  l;
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        l = 8'h00;
        r = 16'h0000;
        case (op)
            OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; l = s[7:0]; c = s[8]; end
            OP_SUB:  begin l = a - b; c = (a < b); end
            OP_MUL:  r = 16'(a) * 16'(b);
            OP_AND:  l = a & b;
            OP_OR:   l = a | b;
            OP_NAND: l = ~(a & b);
            OP_NOR:  l = ~(a | b);
            default: l = a ^ b;
        endcase
        if (op != OP_MUL) r = {8'h00, l};
        return {c, (r == 16'h0000), r};
    endfunction

    always_comb begin
        {bus.alu_c, bus.alu_z, bus.alu_r} = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int         due;
        logic [1:0] addr;
        logic [7:0] val;
    } wb_t;

    typedef struct {
        int   acc;
        int   lat;
        logic fc;
        logic fz;
    } exp_t;

    logic [7:0] m_regs [4];
    logic [7:0] m_nx   [4];
    logic       m_fc, m_fz;
    wb_t        pend[$];
    exp_t       sb[$];
    int         ncyc = 0;
    int         busy_until = 0;
    int         accepts = 0;
    int         n_done = 0;
    logic       chk_ops = 1'b0;
    logic [7:0] exp_a, exp_b;
    logic [2:0] exp_op;
    logic [17:0] m_res;
    exp_t       m_e;
    wb_t        m_w;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_fc = 1'b0;
            m_fz = 1'b0;
            pend.delete();
            sb.delete();
            busy_until = 0;
            chk_ops = 1'b0;
        end else begin
            check("instr_ready", bus.instr_ready, ncyc >= busy_until);
            if (chk_ops) begin
                check("alu_a", bus.alu_a, exp_a);
                check("alu_b", bus.alu_b, exp_b);
                check("alu_op", bus.alu_op, exp_op);
                chk_ops = 1'b0;
            end
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    fail_now("spurious done");
                end else begin
                    m_e = sb.pop_front();
                    check("done latency", 16'(ncyc - m_e.acc), 16'(m_e.lat));
                    check("flag_c", flag_c, m_e.fc);
                    check("flag_z", flag_z, m_e.fz);
                    for (int i = 0; i < 4; i++) begin
                        mon_dbg = 2'(i);
                        #1;
                        check($sformatf("R%0d", i), dbg_data, m_regs[i]);
                    end
                end
            end
            // advance the model by one edge: loads, then scheduled writebacks
            for (int i = 0; i < 4; i++) m_nx[i] = m_regs[i];
            if (ld_en) m_nx[ld_addr] = ld_data;
            while (pend.size() > 0 && pend[0].due == ncyc) begin
                m_w = pend.pop_front();
                m_nx[m_w.addr] = m_w.val;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                accepts++;
                exp_a  = m_regs[bus.instr_rd];
                exp_b  = m_regs[bus.instr_rs];
                exp_op = bus.instr_op;
                chk_ops = 1'b1;
                m_res = ref_alu(bus.instr_op, exp_a, exp_b);
                m_e.acc = ncyc;
                m_e.lat = (bus.instr_op == OP_MUL) ? 4 : 3;
                m_e.fz  = m_res[16];
                m_e.fc  = (bus.instr_op == OP_ADD || bus.instr_op == OP_SUB) ? m_res[17] : m_fc;
                m_fc = m_e.fc;
                m_fz = m_e.fz;
                m_w.due = ncyc + 2; m_w.addr = bus.instr_rd; m_w.val = m_res[7:0];
                pend.push_back(m_w);
                if (bus.instr_op == OP_MUL) begin
                    m_w.due = ncyc + 3; m_w.addr = 2'(bus.instr_rd + 2'd1); m_w.val = m_res[15:8];
                    pend.push_back(m_w);
                end
                sb.push_back(m_e);
                busy_until = ncyc + m_e.lat;
            end
            for (int i = 0; i < 4; i++) m_regs[i] = m_nx[i];
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
        dbg_sel  = 1'b1;
        stim_dbg = a;
        #1;
        v = dbg_data;
        dbg_sel = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd_reg(a, v);
        check(name, v, exp);
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
        logic ok;
        ok = 1'b0;
        bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs = rs;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.instr_ready) ok = 1'b1;
            step();
        end
        bus.instr_valid = 1'b0;
        if (!ok) fail_now("accept timeout");
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (sb.size() == 0 && bus.instr_ready) ok = 1'b1;
            else step();
        end
        if (!ok) fail_now("idle timeout");
    endtask

    initial begin
        int a0, d0;
        bus.instr_valid = 1'b0; bus.instr_op = 3'd0; bus.instr_rd = 2'd0; bus.instr_rs = 2'd0;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00;
        stim_dbg = 2'd0; dbg_sel = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        check("reset flag_c", flag_c, 1'b0);
        check("reset flag_z", flag_z, 1'b0);
        check("reset done", done, 1'b0);
        check("reset ready", bus.instr_ready, 1'b1);
        check("reset alu_op", bus.alu_op, 3'b000);
        for (int i = 0; i < 4; i++) expect_reg("reset R", 2'(i), 8'h00);

        // Add without carry
        load(2'd0, 8'h0F); load(2'd1, 8'h01);
        issue(OP_ADD, 2'd0, 2'd1); wait_idle();
        expect_reg("add R0", 2'd0, 8'h10);
        check("add fc", flag_c, 1'b0);
        check("add fz", flag_z, 1'b0);

        // Add with carry and zero, then And keeps carry
        load(2'd2, 8'hFF); load(2'd1, 8'h01);
        issue(OP_ADD, 2'd2, 2'd1); wait_idle();
        expect_reg("addc R2", 2'd2, 8'h00);
        check("addc fc", flag_c, 1'b1);
        check("addc fz", flag_z, 1'b1);
        issue(OP_AND, 2'd1, 2'd1); wait_idle();
        expect_reg("and R1", 2'd1, 8'h01);
        check("and fz", flag_z, 1'b0);
        check("and fc kept", flag_c, 1'b1);

        // Mul with high byte wrapping to R0
        load(2'd3, 8'h10); load(2'd0, 8'h20);
        issue(OP_MUL, 2'd3, 2'd0); wait_idle();
        expect_reg("mul R3", 2'd3, 8'h00);
        expect_reg("mul R0", 2'd0, 8'h02);
        check("mul fz", flag_z, 1'b0);
        check("mul fc kept", flag_c, 1'b1);

        // back-to-back Sub with valid held high
        a0 = accepts;
        bus.instr_op = OP_SUB; bus.instr_rd = 2'd0; bus.instr_rs = 2'd0;
        bus.instr_valid = 1'b1;
        repeat (9) step();
        bus.instr_valid = 1'b0;
        wait_idle();
        check("sub accepts", 16'(accepts - a0), 16'd3);
        expect_reg("sub R0", 2'd0, 8'h00);
        check("sub fz", flag_z, 1'b1);

        // load collides with CAPT writeback: writeback wins
        load(2'd0, 8'h5A); load(2'd1, 8'h3C);
        issue(OP_XOR, 2'd0, 2'd1);
        step();
        load(2'd0, 8'hAA);
        wait_idle();
        expect_reg("xor wb wins", 2'd0, 8'h66);

        // load in the accept cycle is not forwarded to the operand
        load(2'd0, 8'h11);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'hF0;
        issue(OP_OR, 2'd0, 2'd1);
        ld_en = 1'b0;
        wait_idle();
        expect_reg("or old R0", 2'd0, 8'h3D);

        // reset during EXEC aborts, same-cycle load dropped
        load(2'd0, 8'h55);
        issue(OP_ADD, 2'd0, 2'd0);
        d0 = n_done;
        rst_n = 1'b0;
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h77;
        #1;
        check("rst alu_a", bus.alu_a, 8'h00);
        check("rst alu_b", bus.alu_b, 8'h00);
        check("rst flag_c", flag_c, 1'b0);
        step();
        ld_en = 1'b0;
        rst_n = 1'b1;
        repeat (6) step();
        check("rst no done", 16'(n_done - d0), 16'd0);
        check("rst ready", bus.instr_ready, 1'b1);
        expect_reg("rst R0", 2'd0, 8'h00);
        expect_reg("rst R1 load dropped", 2'd1, 8'h00);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            ld_en   = ($urandom_range(0, 3) == 0);
            ld_addr = 2'($urandom_range(0, 3));
            ld_data = 8'($urandom);
            bus.instr_valid = 1'($urandom_range(0, 1));
            bus.instr_op = 3'($urandom_range(0, 7));
            bus.instr_rd = 2'($urandom_range(0, 3));
            bus.instr_rs = 2'($urandom_range(0, 3));
            step();
        end
        bus.instr_valid = 1'b0;
        ld_en = 1'b0;
        wait_idle();
        step();
        for (int i = 0; i < 4; i++) expect_reg("final R", 2'(i), m_regs[i]);
        check("final fc", flag_c, m_fc);
        check("final fz", flag_z, m_fz);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
